sram_controller: RTL and testbench



---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_slot_timer.sv | 35 +++
 rtl/sram_controller.sv | 195 +++++++++++++++++++
 tb/tb_sram_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared encodings for the cache-to-SRAM request path: FSM states and
// per-transaction halfword counts.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } sram_state_e;

  localparam int unsigned READ_HALFWORDS  = 4;
  localparam int unsigned WRITE_HALFWORDS = 2;

  localparam int unsigned REQ_ADDR_W  = 17;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned HW_W        = 16;
  localparam int unsigned WDATA_W     = 32;
  localparam int unsigned RDATA_W     = 64;
  localparam int unsigned CNT_W       = 32;

endpackage

// File: rtl/sram_slot_timer.sv
// Cycle counter for one SRAM halfword slot, wrapping 0..ACCESS_CYCLES-1.
// slot_penult_o flags that the following cycle is the slot's last one.
module sram_slot_timer #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic slot_last_o,
  output logic slot_penult_o
);

  localparam int unsigned TMR_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign slot_last_o   = (cnt_q == TMR_W'(ACCESS_CYCLES - 1));
  assign slot_penult_o = (cnt_q == TMR_W'(ACCESS_CYCLES - 2));

  always_comb begin
    cnt_d = cnt_q + TMR_W'(1);
    if (clear_i || slot_last_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Sequences cache word writes / doubleword reads as 16-bit async SRAM accesses.
// Optional SRAM_PERF_CNT_EN adds read_count/write_count completion counters.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REQ_ADDR_W-1:0]  sram_address,
  input  logic [WDATA_W-1:0]     sram_wdata,
  input  logic                   sram_write,
  input  logic                   sram_read,
  output logic [RDATA_W-1:0]     sram_rdata,
  output logic                   sram_ready,
  inout  wire  [HW_W-1:0]        SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
`ifdef SRAM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       read_count,
  output logic [CNT_W-1:0]       write_count
`endif
);

  sram_state_e            state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic [REQ_ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [HW_W-1:0]        wdata_hi_q, wdata_hi_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   dq_oe_q, dq_oe_d;
  logic [HW_W-1:0]        dq_out_q, dq_out_d;
  logic [RDATA_W-1:0]     rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic [1:0]             k_nxt;
  logic                   slot_last;
  logic                   slot_penult;
  logic                   tmr_clear;
`ifdef SRAM_PERF_CNT_EN
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
`endif

  assign tmr_clear = (state_q != READ) && (state_q != WRITE);
  assign k_nxt     = k_q + 2'd1;

  sram_slot_timer #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_slot_timer (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (tmr_clear),
    .slot_last_o   (slot_last),
    .slot_penult_o (slot_penult)
  );

  // Next-state and next-output logic; all pin controls are registered from here.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    req_addr_d = req_addr_q;
    wdata_hi_d = wdata_hi_q;
    addr_d     = addr_q;
    we_n_d     = we_n_q;
    oe_n_d     = oe_n_q;
    dq_oe_d    = dq_oe_q;
    dq_out_d   = dq_out_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
`ifdef SRAM_PERF_CNT_EN
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sram_write) begin
          state_d    = WRITE;
          k_d        = 2'd0;
          req_addr_d = sram_address;
          wdata_hi_d = sram_wdata[31:16];
          addr_d     = {sram_address, 1'b0};
          dq_out_d   = sram_wdata[15:0];
          dq_oe_d    = 1'b1;
          we_n_d     = 1'b0;
        end else if (sram_read) begin
          state_d    = READ;
          k_d        = 2'd0;
          req_addr_d = sram_address;
          addr_d     = {sram_address[16:1], 2'b00};
          oe_n_d     = 1'b0;
        end
      end
      READ: begin
        if (slot_last) begin
          // Halfwords arrive lowest first, so shifting in from the top lands halfword k at [16k+15:16k].
          rdata_d = {SRAM_DQ, rdata_q[RDATA_W-1:HW_W]};
          if (k_q == 2'(READ_HALFWORDS - 1)) begin
            state_d = DONE;
            oe_n_d  = 1'b1;
            ready_d = 1'b1;
`ifdef SRAM_PERF_CNT_EN
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
`endif
          end else begin
            k_d    = k_nxt;
            addr_d = {req_addr_q[16:1], k_nxt};
          end
        end
      end
      WRITE: begin
        if (slot_last) begin
          if (k_q == 2'(WRITE_HALFWORDS - 1)) begin
            state_d = DONE;
            dq_oe_d = 1'b0;
            we_n_d  = 1'b1;
            ready_d = 1'b1;
`ifdef SRAM_PERF_CNT_EN
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
`endif
          end else begin
            k_d      = k_nxt;
            addr_d   = {req_addr_q, 1'b1};
            dq_out_d = wdata_hi_q;
            we_n_d   = 1'b0;
          end
        end else if (slot_penult) begin
          // Raise WE_N one cycle early so the last cycle of the slot holds address/data with WE_N high.
          we_n_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      req_addr_q <= '0;
      wdata_hi_q <= '0;
      addr_q     <= '0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
`ifdef SRAM_PERF_CNT_EN
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      req_addr_q <= req_addr_d;
      wdata_hi_q <= wdata_hi_d;
      addr_q     <= addr_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
`ifdef SRAM_PERF_CNT_EN
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
`endif
    end
  end

  assign SRAM_DQ    = dq_oe_q ? dq_out_q : {HW_W{1'bz}};
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;
  assign sram_rdata = rdata_q;
  assign sram_ready = ready_q;
`ifdef SRAM_PERF_CNT_EN
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit async SRAM model.
module tb_sram_controller;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_write;
  logic        sram_read;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
`ifdef SRAM_PERF_CNT_EN
  logic [31:0] read_count;
  logic [31:0] write_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  sram_controller #(.ACCESS_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_write   (sram_write),
    .sram_read    (sram_read),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
    .SRAM_DQ      (sram_dq),
    .SRAM_ADDR    (sram_addr),
    .SRAM_WE_N    (sram_we_n),
    .SRAM_OE_N    (sram_oe_n),
    .SRAM_CE_N    (sram_ce_n),
    .SRAM_UB_N    (sram_ub_n),
    .SRAM_LB_N    (sram_lb_n)
`ifdef SRAM_PERF_CNT_EN
    ,
    .read_count   (read_count),
    .write_count  (write_count)
`endif
  );

  // SRAM model: drives data while OE_N low and WE_N high, stores on WE_N rising edge.
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1111;
    mem[8'h11] = 16'h2222;
    mem[8'h12] = 16'h3333;
    mem[8'h13] = 16'h4444;
    forever begin
      @(posedge sram_we_n);
      mem[sram_addr[7:0]] = sram_dq;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [17:0] w_addr [4];
  logic        w_we_n [4];
  logic [15:0] w_data [4];
  int          pulses;
  int          pulse_cyc;
  int          oe_low;

  initial begin
    rst          = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    sram_write   = 1'b0;
    sram_read    = 1'b0;
    w_addr = '{18'h0E, 18'h0E, 18'h0F, 18'h0F};
    w_we_n = '{1'b0, 1'b1, 1'b0, 1'b1};
    w_data = '{16'hBABE, 16'hBABE, 16'hCAFE, 16'hCAFE};

    // Reset held three cycles, then released with no request.
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    chk("rst_ready", 64'(sram_ready), 64'd0);
    chk("rst_we_n", 64'(sram_we_n), 64'd1);
    chk("rst_oe_n", 64'(sram_oe_n), 64'd1);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_rdata", sram_rdata, 64'd0);
    chk("rst_dq_released", 64'(dut.dq_oe_q), 64'd0);
    chk("rst_ce_ub_lb", 64'({sram_ce_n, sram_ub_n, sram_lb_n}), 64'd0);

    // Doubleword read of halfwords 0x10..0x13.
    sram_address = 17'h0008;
    sram_read    = 1'b1;
    step();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("rd_addr_c%0d", c), 64'(sram_addr), 64'(18'h10 + 18'((c - 1) / 2)));
      chk($sformatf("rd_oe_n_c%0d", c), 64'(sram_oe_n), 64'd0);
      chk($sformatf("rd_we_n_c%0d", c), 64'(sram_we_n), 64'd1);
      chk($sformatf("rd_ready_c%0d", c), 64'(sram_ready), 64'd0);
      step();
    end
    chk("rd_ready_c9", 64'(sram_ready), 64'd1);
    chk("rd_rdata", sram_rdata, 64'h4444_3333_2222_1111);
    sram_read = 1'b0;
    step();
    chk("rd_ready_c10", 64'(sram_ready), 64'd0);
    chk("rd_oe_n_c10", 64'(sram_oe_n), 64'd1);
    chk("rd_state_c10", 64'(dut.state_q), 64'(IDLE));

    // Word write to halfwords 0x0E/0x0F.
    sram_address = 17'h0007;
    sram_wdata   = 32'hCAFE_BABE;
    sram_write   = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("wr_addr_c%0d", c + 1), 64'(sram_addr), 64'(w_addr[c]));
      chk($sformatf("wr_we_n_c%0d", c + 1), 64'(sram_we_n), 64'(w_we_n[c]));
      chk($sformatf("wr_dq_c%0d", c + 1), 64'(sram_dq), 64'(w_data[c]));
      chk($sformatf("wr_oe_n_c%0d", c + 1), 64'(sram_oe_n), 64'd1);
      chk($sformatf("wr_ready_c%0d", c + 1), 64'(sram_ready), 64'd0);
      step();
    end
    chk("wr_ready_c5", 64'(sram_ready), 64'd1);
    chk("wr_rdata_kept", sram_rdata, 64'h4444_3333_2222_1111);
`ifdef SRAM_PERF_CNT_EN
    chk("cnt_rd_after_wr", 64'(read_count), 64'd1);
    chk("cnt_wr_after_wr", 64'(write_count), 64'd1);
`endif
    sram_write = 1'b0;
    step();
    chk("wr_ready_c6", 64'(sram_ready), 64'd0);
    chk("wr_mem_0e", 64'(mem[8'h0E]), 64'hBABE);
    chk("wr_mem_0f", 64'(mem[8'h0F]), 64'hCAFE);

    // Read and write together: write wins, single completion.
    sram_address = 17'h0009;
    sram_wdata   = 32'h1234_5678;
    sram_write   = 1'b1;
    sram_read    = 1'b1;
    pulses = 0; pulse_cyc = 0; oe_low = 0;
    step();
    for (int c = 1; c <= 10; c++) begin
      if (!sram_oe_n) oe_low++;
      if (sram_ready) begin
        pulses++;
        pulse_cyc  = c;
        sram_write = 1'b0;
        sram_read  = 1'b0;
      end
      step();
    end
    chk("both_pulses", 64'(pulses), 64'd1);
    chk("both_pulse_cycle", 64'(pulse_cyc), 64'd5);
    chk("both_no_oe", 64'(oe_low), 64'd0);
    chk("both_rdata_kept", sram_rdata, 64'h4444_3333_2222_1111);
    chk("both_mem_12", 64'(mem[8'h12]), 64'h5678);
    chk("both_mem_13", 64'(mem[8'h13]), 64'h1234);
`ifdef SRAM_PERF_CNT_EN
    chk("cnt_wr_after_both", 64'(write_count), 64'd2);
`endif

    // Reset in cycle 4 of a read.
    sram_address = 17'h0009;
    sram_read    = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    step();
    chk("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
    chk("mid_rst_oe_n", 64'(sram_oe_n), 64'd1);
    chk("mid_rst_rdata", sram_rdata, 64'd0);
    chk("mid_rst_ready", 64'(sram_ready), 64'd0);
    rst       = 1'b1;
    sram_read = 1'b0;
    step();
    chk("mid_rst_idle_ready", 64'(sram_ready), 64'd0);

    // Fresh read after reset, then held for 10 more cycles.
    sram_read = 1'b1;
    repeat (8) step();
    chk("rd2_ready_c8", 64'(sram_ready), 64'd0);
    step();
    chk("rd2_ready_c9", 64'(sram_ready), 64'd1);
    chk("rd2_rdata", sram_rdata, 64'h1234_5678_2222_1111);
    pulses = 0; pulse_cyc = 0;
    for (int c = 10; c <= 19; c++) begin
      step();
      if (sram_ready) begin
        pulses++;
        pulse_cyc = c;
      end
    end
    chk("held_pulses", 64'(pulses), 64'd1);
    chk("held_pulse_cycle", 64'(pulse_cyc), 64'd19);
`ifdef SRAM_PERF_CNT_EN
    chk("cnt_rd_final", 64'(read_count), 64'd2);
    chk("cnt_wr_final", 64'(write_count), 64'd0);
`endif
    sram_read = 1'b0;
    repeat (2) step();
    chk("end_state", 64'(dut.state_q), 64'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
